// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    if (chunk < 1) begin
      return 1;
    end else begin
      return width / chunk;
    end
  endfunction

  // A single-chunk configuration still needs a 1-bit index.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/chunked_adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] total;

  // One extra bit captures the carry out of the slice.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    s     = total[CHUNK-1:0];
    co    = total[CHUNK];
  end

endmodule

// File: rtl/chunked_adder.sv
// Adds two WIDTH-bit operands CHUNK bits per cycle, with valid/ready on both sides.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("chunked_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  int unsigned       shift_amt;
  logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_s;
  logic              chunk_co;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // Operand slice selection, next-state and datapath updates.
  always_comb begin
    shift_amt = int'(idx_q) * CHUNK;
    chunk_a   = CHUNK'(a_q >> shift_amt);
    chunk_b   = CHUNK'(b_q >> shift_amt);
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        sum_d   = (sum_q & ~(CHUNK_MASK << shift_amt)) | (WIDTH'(chunk_s) << shift_amt);
        carry_d = chunk_co;
        idx_d   = idx_q + IDXW'(1'b1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = chunk_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule
